program_loader: RTL and testbench

Boot-time program loader that writes the program memory while the control unit is held disabled. It is the write side of the program-memory interface: it receives a framed byte stream from a host link, assembles bytes into instruction words, writes them sequentially from address 0 and checks a frame checksum. Only a successful load raises `cpu_enable`, which drives the control unit's `enable`.

---
 rtl/program_loader.sv | 113 +++++++++++
 tb/tb_program_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: framed byte-stream program-memory loader; checksum byte handled when LOADER_CHECKSUM_EN is defined
module program_loader #(
   parameter int WORD_BYTES = 2,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    prog_wr_en,
   output logic [ADDR_WIDTH-1:0]   prog_wr_address,
   output logic [8*WORD_BYTES-1:0] prog_wr_data,
   output logic                    cpu_enable,
   output logic                    load_busy,
   output logic                    load_error
);
   localparam int W = 8 * WORD_BYTES;
   localparam int BW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;
   localparam int RW = ADDR_WIDTH + 1;
   localparam logic [31:0] DEPTH = 32'd1 << ADDR_WIDTH;
   localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE, CHECK, DONE, ERROR} state_t;
   localparam state_t TAIL = CHECK;
   logic [7:0] acc;
`else
   typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE, DONE, ERROR} state_t;
   localparam state_t TAIL = DONE;
`endif

   state_t state, next;
   logic accept, start, overflow, count_zero, last_byte, last_word;
   logic [7:0] cnt_hi;
   logic [RW-1:0] rem;
   logic [BW-1:0] byte_idx;
   logic [W-1:0] word;
   logic [ADDR_WIDTH-1:0] addr;

   assign accept = in_valid & in_ready;
   assign start = accept && in_data == 8'hA5 && !load_busy;
   assign overflow = {16'd0, cnt_hi, in_data} > DEPTH;
   assign count_zero = {cnt_hi, in_data} == 16'd0;
   assign last_byte = byte_idx == LAST_BYTE;
   assign last_word = rem == RW'(1);
   assign prog_wr_address = addr;
   assign prog_wr_data = word;

   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= next;

   // next-state decode; 0xA5 only resynchronises outside a frame
   always_comb begin
      next = state;
      case (state)
         IDLE, DONE, ERROR: if (accept && in_data == 8'hA5) next = CNT_HI;
         CNT_HI: if (accept) next = CNT_LO;
         CNT_LO: if (accept) next = overflow ? ERROR : count_zero ? TAIL : DATA;
         DATA: if (accept && last_byte) next = WRITE;
         WRITE: next = last_word ? TAIL : DATA;
`ifdef LOADER_CHECKSUM_EN
         CHECK: if (accept) next = in_data == acc ? DONE : ERROR;
`endif
         default: next = IDLE;
      endcase
   end

   // decoded handshake and status outputs
   always_comb begin
      in_ready = state != WRITE;
      prog_wr_en = state == WRITE;
      load_busy = !(state inside {IDLE, DONE, ERROR});
   end

   // frame datapath: count, word assembly, write address
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt_hi <= '0;
         rem <= '0;
         byte_idx <= '0;
         word <= '0;
         addr <= '0;
      end else begin
         if (accept && state == CNT_HI) cnt_hi <= in_data;
         if (accept && state == CNT_LO) rem <= RW'({cnt_hi, in_data});
         else if (state == WRITE) rem <= rem - 1'b1;
         if (start) byte_idx <= '0;
         else if (accept && state == DATA) byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
         if (accept && state == DATA) word <= W'({word, in_data});
         addr <= start ? '0 : state == WRITE ? addr + 1'b1 : addr;
      end

`ifdef LOADER_CHECKSUM_EN
   // running XOR of count and data bytes, sync byte excluded
   always_ff @(posedge clk or negedge reset)
      if (!reset) acc <= '0;
      else if (start) acc <= '0;
      else if (accept && state inside {CNT_HI, CNT_LO, DATA}) acc <= acc ^ in_data;
`endif

   // registered load verdict follows the state being entered
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cpu_enable <= 1'b0;
         load_error <= 1'b0;
      end else begin
         cpu_enable <= next == DONE;
         load_error <= next == ERROR;
      end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: scoreboard bench for program_loader (checksum frames when LOADER_CHECKSUM_EN is defined)
module tb_program_loader;
   logic clk = 0, reset = 0, in_valid = 0;
   logic [7:0] in_data = 0;
   logic in_ready, prog_wr_en, cpu_enable, load_busy, load_error;
   logic [7:0] prog_wr_address;
   logic [15:0] prog_wr_data;
   int checks = 0, errors = 0, exp_writes = 0, ready_low = 0;
   logic [23:0] exp_q[$];
   logic [23:0] e;
   logic [15:0] wq[$];

   program_loader dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .prog_wr_en(prog_wr_en), .prog_wr_address(prog_wr_address), .prog_wr_data(prog_wr_data),
      .cpu_enable(cpu_enable), .load_busy(load_busy), .load_error(load_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: every write strobe must match the next expected write
   always @(negedge clk)
      if (reset) begin
         if (!in_ready) ready_low++;
         if (prog_wr_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write got addr %0h data %0h expected no write", prog_wr_address, prog_wr_data);
            end else begin
               e = exp_q.pop_front();
               chk("write_addr", 32'(prog_wr_address), 32'(e[23:16]));
               chk("write_data", 32'(prog_wr_data), 32'(e[15:0]));
               chk("ready_in_write", 32'(in_ready), 0);
            end
         end
      end

   task automatic send(input logic [7:0] b);
      int n = 0;
      in_data = b;
      in_valid = 1;
      while (!in_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got in_ready 0 expected 1");
      end
      @(negedge clk);
   endtask

   task automatic check_reset_values();
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_wr_en", 32'(prog_wr_en), 0);
      chk("rst_addr", 32'(prog_wr_address), 0);
      chk("rst_data", 32'(prog_wr_data), 0);
      chk("rst_cpu_enable", 32'(cpu_enable), 0);
      chk("rst_busy", 32'(load_busy), 0);
      chk("rst_error", 32'(load_error), 0);
   endtask

   task automatic load(input int cnt, input bit bad, input bit exp_ok);
      logic [15:0] c;
      logic [7:0] ck;
      c = 16'(cnt);
      ck = c[15:8] ^ c[7:0];
      send(8'hA5);
      chk("busy_after_sync", 32'(load_busy), 1);
      chk("cpu_cleared", 32'(cpu_enable), 0);
      chk("err_cleared", 32'(load_error), 0);
      send(c[15:8]);
      send(c[7:0]);
      if (cnt <= 256)
         for (int i = 0; i < cnt; i++) begin
            exp_q.push_back({8'(i), wq[i]});
            exp_writes++;
            send(wq[i][15:8]);
            send(wq[i][7:0]);
            ck = ck ^ wq[i][15:8] ^ wq[i][7:0];
         end
`ifdef LOADER_CHECKSUM_EN
      if (cnt <= 256) begin
         chk("cpu_before_ck", 32'(cpu_enable), 0);
         send(ck ^ {7'd0, bad});
      end
`else
      if (bad) ck = 0;
      if (cnt > 0 && cnt <= 256) @(negedge clk);
`endif
      in_valid = 0;
      chk("cpu_enable", 32'(cpu_enable), 32'(exp_ok));
      chk("load_error", 32'(load_error), 32'(!exp_ok));
      chk("busy_end", 32'(load_busy), 0);
      repeat (2) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_reset_values();
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      send(8'h00);
      send(8'h11);
      in_valid = 0;
      wq = '{16'h1234, 16'hABCD};
      load(2, 0, 1);
`ifdef LOADER_CHECKSUM_EN
      load(2, 1, 0);
      load(2, 0, 1);
`endif
      load(257, 0, 0);
      load(0, 0, 1);
      wq = '{16'hA5A5, 16'h00FF, 16'h5A01};
      load(3, 0, 1);
      wq.delete();
      for (int i = 0; i < 256; i++) wq.push_back({8'(i), ~8'(i)});
      load(256, 0, 1);
      exp_q.push_back({8'h00, 16'h1234});
      exp_writes++;
      send(8'hA5);
      send(8'h00);
      send(8'h02);
      send(8'h12);
      send(8'h34);
      send(8'hAB);
      in_valid = 0;
      #2 reset = 0;
      #1 check_reset_values();
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      chk("reset_queue", exp_q.size(), 0);
      wq = '{16'h1234, 16'hABCD};
      load(2, 0, 1);
      chk("ready_low_cycles", ready_low, exp_writes);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
